// File: rtl/bcd_scan_mux_if.sv
// ============================================================================
//  Module      : bcd_scan_mux_if
//  Description : Digit data / display-scan bundle for bcd_scan_mux.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_scan_mux_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] bcd_in;
    logic                load;
    logic [3:0]          bcd_out;
    logic                bi_n;
    logic [DIGITS-1:0]   dig_sel;
    logic                frame_done;
    logic                bcd_err;

    modport master (
        output bcd_in,
        output load,
        input  bcd_out,
        input  bi_n,
        input  dig_sel,
        input  frame_done,
        input  bcd_err
    );

    modport slave (
        input  bcd_in,
        input  load,
        output bcd_out,
        output bi_n,
        output dig_sel,
        output frame_done,
        output bcd_err
    );
endinterface

`default_nettype wire

// File: rtl/bcd_scan_mux.sv
// ============================================================================
//  Module      : bcd_scan_mux
//  Description : Time-multiplexed BCD scanner for a common-cathode 7-seg
//                display with per-slot blanking and frame-aligned updates.
//                Optional macro LZB_EN enables leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_scan_mux #(
    parameter int DIGITS    = 4,
    parameter int DIV       = 8,
    parameter int BLANK_CYC = 2
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    bcd_scan_mux_if.slave bus
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = 4 * DIGITS;

    localparam logic [PW-1:0] P_LAST   = PW'(DIV - 1);
    localparam logic [PW-1:0] P_SHOW   = PW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t            r_state;
    logic [PW-1:0]     r_p;
    logic [IW-1:0]     r_idx;
    logic [DW-1:0]     r_shadow;
    logic [DW-1:0]     r_pend;
    logic              r_pend_vld;
    logic [3:0]        r_bcd_out;
    logic              r_bi_n;
    logic [DIGITS-1:0] r_dig_sel;
    logic              r_frame_done;
    logic              r_bcd_err;

    state_t            w_state_nx;
    logic [PW-1:0]     w_p_nx;
    logic [IW-1:0]     w_idx_nx;
    logic [DW-1:0]     w_shadow_nx;
    logic [DW-1:0]     w_pend_nx;
    logic              w_pend_vld_nx;
    logic              w_slot_end;
    logic              w_frame_end;
    logic [3:0]        w_nib;
    logic              w_show;
    logic              w_lzb_blank;

`ifdef LZB_EN
    // Bit k is set when digits k..DIGITS-1 are all zero; digit 0 never blanks.
    logic [DIGITS-1:0] w_tail_zero;
    assign w_tail_zero[0] = 1'b0;
    for (genvar k = 1; k < DIGITS; k++) begin : g_tail_zero
        assign w_tail_zero[k] = ~|w_shadow_nx[DW-1:4*k];
    end
    assign w_lzb_blank = w_tail_zero[w_idx_nx];
`else
    assign w_lzb_blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_BLANK;
            r_p          <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_pend       <= '0;
            r_pend_vld   <= 1'b0;
            r_bcd_out    <= 4'd0;
            r_bi_n       <= 1'b0;
            r_dig_sel    <= '0;
            r_frame_done <= 1'b0;
            r_bcd_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_p          <= w_p_nx;
            r_idx        <= w_idx_nx;
            r_shadow     <= w_shadow_nx;
            r_pend       <= w_pend_nx;
            r_pend_vld   <= w_pend_vld_nx;
            r_bcd_out    <= w_nib;
            r_bi_n       <= w_show && !w_lzb_blank;
            r_dig_sel    <= w_show ? (DIGITS'(1) << w_idx_nx) : '0;
            r_frame_done <= (w_p_nx == P_LAST) && (w_idx_nx == IDX_LAST);
            r_bcd_err    <= w_show && (w_nib > 4'd9);
        end
    end

    // Outputs are registered from next-state values so they line up with the
    // slot position held in r_p / r_idx.
    always_comb begin
        w_slot_end    = (r_p == P_LAST);
        w_frame_end   = w_slot_end && (r_idx == IDX_LAST);
        w_p_nx        = w_slot_end ? '0 : r_p + PW'(1);
        w_idx_nx      = r_idx;
        w_state_nx    = r_state;
        w_shadow_nx   = r_shadow;
        w_pend_nx     = r_pend;
        w_pend_vld_nx = r_pend_vld;

        if (w_slot_end) begin
            w_idx_nx = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
        end

        case (r_state)
            ST_BLANK: if (w_p_nx == P_SHOW) w_state_nx = ST_SHOW;
            ST_SHOW:  if (w_slot_end)       w_state_nx = ST_BLANK;
            default:  w_state_nx = ST_BLANK;
        endcase

        // Shadow only changes at the frame boundary so a frame is never mixed.
        if (w_frame_end) begin
            w_pend_vld_nx = 1'b0;
            if (bus.load) begin
                w_shadow_nx = bus.bcd_in;
            end else if (r_pend_vld) begin
                w_shadow_nx = r_pend;
            end
        end else if (bus.load) begin
            w_pend_nx     = bus.bcd_in;
            w_pend_vld_nx = 1'b1;
        end

        w_show = (w_state_nx == ST_SHOW);
        w_nib  = w_shadow_nx[{w_idx_nx, 2'b00} +: 4];
    end

    assign bus.bcd_out    = r_bcd_out;
    assign bus.bi_n       = r_bi_n;
    assign bus.dig_sel    = r_dig_sel;
    assign bus.frame_done = r_frame_done;
    assign bus.bcd_err    = r_bcd_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_scan_mux.sv
// ============================================================================
//  Module      : tb_bcd_scan_mux
//  Description : Self-checking bench for bcd_scan_mux against a time-index
//                reference model, with directed and randomized loads/resets.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_scan_mux;

    localparam int DIGITS    = 4;
    localparam int DIV       = 8;
    localparam int BLANK_CYC = 2;
    localparam int DW        = 4 * DIGITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_scan_mux_if #(.DIGITS(DIGITS)) bus ();

    bcd_scan_mux #(
        .DIGITS   (DIGITS),
        .DIV      (DIV),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // Model: t counts cycles since reset release; shadow/pending as plain data.
    int            t;
    logic [DW-1:0] m_shadow;
    logic [DW-1:0] m_pend;
    bit            m_pend_vld;
    int            vectors;
    int            miscompares;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", name, t, got, exp);
        end
    endtask

    task automatic cmp_model();
        int            p;
        int            d;
        bit            show;
        logic [3:0]    nib;
        logic [DW-1:0] upper;
        bit            lzb;
        p     = t % DIV;
        d     = (t / DIV) % DIGITS;
        show  = (p >= BLANK_CYC);
        upper = m_shadow >> (4 * d);
        nib   = upper[3:0];
`ifdef LZB_EN
        lzb   = (d > 0) && (upper == '0);
`else
        lzb   = 1'b0;
`endif
        chk("dig_sel",    32'(bus.dig_sel),    show ? (32'd1 << d) : 32'd0);
        chk("bcd_out",    32'(bus.bcd_out),    32'(nib));
        chk("bi_n",       32'(bus.bi_n),       32'(show && !lzb));
        chk("bcd_err",    32'(bus.bcd_err),    32'(show && (nib > 4'd9)));
        chk("frame_done", 32'(bus.frame_done), 32'((p == DIV-1) && (d == DIGITS-1)));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare.
    task automatic step(input bit ld, input logic [DW-1:0] val);
        bit frame_end;
        bus.load   = ld;
        bus.bcd_in = val;
        frame_end  = ((t % DIV) == DIV-1) && (((t / DIV) % DIGITS) == DIGITS-1);
        if (frame_end) begin
            if (ld)              m_shadow = val;
            else if (m_pend_vld) m_shadow = m_pend;
            m_pend_vld = 1'b0;
        end else if (ld) begin
            m_pend     = val;
            m_pend_vld = 1'b1;
        end
        t++;
        @(negedge clk);
        cmp_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_dig_sel",    32'(bus.dig_sel),    32'd0);
        chk("rst_bcd_out",    32'(bus.bcd_out),    32'd0);
        chk("rst_bi_n",       32'(bus.bi_n),       32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_bcd_err",    32'(bus.bcd_err),    32'd0);
        m_shadow   = '0;
        m_pend     = '0;
        m_pend_vld = 1'b0;
        bus.load   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t     = 0;
        cmp_model();
    endtask

    // Hand-computed expectations for the directed run (phase 0) and the
    // restart after the mid-slot reset (phase 1).
    task automatic pin(input int phase);
        if (phase == 0) begin
            case (t)
                2:   chk("pin_first_show", 32'(bus.dig_sel), 32'h1);
                31:  chk("pin_fd0",        32'(bus.frame_done), 32'd1);
                34:  chk("pin_1234_d0",    32'(bus.bcd_out), 32'h4);
                50:  chk("pin_1234_d2",    32'(bus.bcd_out), 32'h2);
                58:  begin
                         chk("pin_1234_d3",  32'(bus.bcd_out), 32'h1);
                         chk("pin_sel_d3",   32'(bus.dig_sel), 32'h8);
                     end
                63:  chk("pin_fd1",        32'(bus.frame_done), 32'd1);
                66:  chk("pin_5678_d0",    32'(bus.bcd_out), 32'h8);
                90:  chk("pin_5678_d3",    32'(bus.bcd_out), 32'h5);
                98:  chk("pin_a7_d0_err",  32'(bus.bcd_err), 32'd0);
                104: begin
                         chk("pin_a7_blank_out", 32'(bus.bcd_out), 32'hA);
                         chk("pin_a7_blank_err", 32'(bus.bcd_err), 32'd0);
                     end
                106: chk("pin_a7_show_err", 32'(bus.bcd_err), 32'd1);
                138: chk("pin_70_d1_bi",   32'(bus.bi_n), 32'd1);
`ifdef LZB_EN
                146: chk("pin_70_d2_bi",   32'(bus.bi_n), 32'd0);
`else
                146: chk("pin_70_d2_bi",   32'(bus.bi_n), 32'd1);
`endif
                default: ;
            endcase
        end else if (t == 34) begin
            chk("pin_pend_discard", 32'(bus.bcd_out), 32'h0);
        end
    endtask

    initial begin
        bit            ld;
        logic [DW-1:0] val;
        logic [DW-1:0] mask;
        vectors     = 0;
        miscompares = 0;
        t           = 0;
        m_shadow    = '0;
        m_pend      = '0;
        m_pend_vld  = 1'b0;
        bus.load    = 1'b0;
        bus.bcd_in  = '0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cmp_model();

        // Directed: 1234, mid-frame 5678, 00A7, 0070, then a doomed 9999.
        while (t < 181) begin
            ld  = 1'b1;
            case (t)
                5:       val = 16'h1234;
                40:      val = 16'h5678;
                70:      val = 16'h00A7;
                100:     val = 16'h0070;
                170:     val = 16'h9999;
                default: begin ld = 1'b0; val = '0; end
            endcase
            step(ld, val);
            pin(0);
        end
        // t=181 is slot p=5 of digit 2 with 9999 still pending.
        do_reset();
        repeat (40) begin
            step(1'b0, '0);
            pin(1);
        end

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       mask = 16'hFFFF;
                1:       mask = 16'h0FFF;
                2:       mask = 16'h00FF;
                default: mask = 16'h000F;
            endcase
            val = DW'($urandom) & mask;
            ld  = ($urandom_range(0, 4) == 0);
            step(ld, val);
            if ($urandom_range(0, 699) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
